// File: rtl/rr_arb.sv
// Round-robin arbiter for the shared REQ/GRANT bus: rotating fairness, a bounded
// hold time per owner and a guaranteed dead cycle between consecutive owners.
module rr_arb #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N-1:0]         REQ,
    output logic [N-1:0]         GRANT,
    output logic                 GRANT_VLD,
    output logic [$clog2(N)-1:0] OWNER,
    output logic                 TIMEOUT
);
    localparam int OW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Scan downward so the candidate closest to ptr is the last one written and wins.
    function automatic logic [OW:0] rr_pick(input logic [N-1:0] req, input logic [OW-1:0] ptr);
        logic [OW:0] res;
        int          idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                res = {1'b1, OW'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [OW-1:0] ptr_after(input logic [OW-1:0] own);
        return (int'(own) == N - 1) ? '0 : own + OW'(1);
    endfunction

    state_t           r_state;
    logic [OW-1:0]    r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [N-1:0]     r_grant;
    logic             r_vld;
    logic [OW-1:0]    r_owner;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [OW-1:0]    w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [N-1:0]     w_grant_nxt;
    logic [OW-1:0]    w_owner_nxt;
    logic             w_timeout_nxt;
    logic [OW:0]      w_pick;

    // State register and all registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_grant    <= '0;
            r_vld      <= 1'b0;
            r_owner    <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_vld      <= |w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Next-state: arbitrate when nobody owns the bus, otherwise watch release and hold limit.
    always_comb begin
        w_pick        = rr_pick(REQ, r_ptr);
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_hold_cnt;
        w_grant_nxt   = r_grant;
        w_owner_nxt   = r_owner;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                w_cnt_nxt = '0;
                if (w_pick[OW]) begin
                    w_state_nxt = ST_BUSY;
                    w_owner_nxt = w_pick[OW-1:0];
                    w_grant_nxt = {{(N-1){1'b0}}, 1'b1} << w_pick[OW-1:0];
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end
            end
            ST_BUSY: begin
                // A release at the limit edge takes precedence, so no TIMEOUT pulse then.
                if (!REQ[r_owner]) begin
                    w_state_nxt = ST_GAP;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = ptr_after(r_owner);
                end else if (r_hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                    w_state_nxt   = ST_GAP;
                    w_grant_nxt   = '0;
                    w_cnt_nxt     = '0;
                    w_ptr_nxt     = ptr_after(r_owner);
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign GRANT     = r_grant;
    assign GRANT_VLD = r_vld;
    assign OWNER     = r_owner;
    assign TIMEOUT   = r_timeout;
endmodule
